// File: rtl/mux16_w.sv
// 16:1 word multiplexer used as the fetch-stage opcode decode table.
// Combinational selection on out, plus a registered copy on out_q.
module mux16_w #(
  parameter int unsigned BITS = 8
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [3:0]      addr,
  input  logic [BITS-1:0] in0,
  input  logic [BITS-1:0] in1,
  input  logic [BITS-1:0] in2,
  input  logic [BITS-1:0] in3,
  input  logic [BITS-1:0] in4,
  input  logic [BITS-1:0] in5,
  input  logic [BITS-1:0] in6,
  input  logic [BITS-1:0] in7,
  input  logic [BITS-1:0] in8,
  input  logic [BITS-1:0] in9,
  input  logic [BITS-1:0] in10,
  input  logic [BITS-1:0] in11,
  input  logic [BITS-1:0] in12,
  input  logic [BITS-1:0] in13,
  input  logic [BITS-1:0] in14,
  input  logic [BITS-1:0] in15,
  output logic [BITS-1:0] out,
  output logic [BITS-1:0] out_q
);

  logic [BITS-1:0] sel_s;
  logic [BITS-1:0] out_d;
  logic [BITS-1:0] out_r;

  // Word select; an unknown address in simulation falls to the default and yields X.
  always_comb begin
    sel_s = {BITS{1'b0}};
    case (addr)
      4'd0:    sel_s = in0;
      4'd1:    sel_s = in1;
      4'd2:    sel_s = in2;
      4'd3:    sel_s = in3;
      4'd4:    sel_s = in4;
      4'd5:    sel_s = in5;
      4'd6:    sel_s = in6;
      4'd7:    sel_s = in7;
      4'd8:    sel_s = in8;
      4'd9:    sel_s = in9;
      4'd10:   sel_s = in10;
      4'd11:   sel_s = in11;
      4'd12:   sel_s = in12;
      4'd13:   sel_s = in13;
      4'd14:   sel_s = in14;
      4'd15:   sel_s = in15;
      default: sel_s = {BITS{1'bx}};
    endcase
  end

  assign out   = sel_s;
  assign out_d = sel_s;

  // Pipelined copy of the selection; cleared asynchronously while nrst is low.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      out_r <= {BITS{1'b0}};
    end else begin
      out_r <= out_d;
    end
  end

  assign out_q = out_r;

endmodule

// File: tb/tb_mux16_w.sv
// Directed self-checking bench for mux16_w at BITS=9.
module tb_mux16_w;

  localparam int unsigned BITS = 9;

  logic            clk;
  logic            nrst;
  logic [3:0]      addr;
  logic [BITS-1:0] tbl [16];
  logic [BITS-1:0] out;
  logic [BITS-1:0] out_q;

  // Hand-written decoder words; each entry distinct so a wrong index shows up.
  logic [BITS-1:0] words [16];

  int n_checks = 0;
  int n_pass   = 0;

  mux16_w #(.BITS(BITS)) dut (
    .clk(clk), .nrst(nrst), .addr(addr),
    .in0(tbl[0]),   .in1(tbl[1]),   .in2(tbl[2]),   .in3(tbl[3]),
    .in4(tbl[4]),   .in5(tbl[5]),   .in6(tbl[6]),   .in7(tbl[7]),
    .in8(tbl[8]),   .in9(tbl[9]),   .in10(tbl[10]), .in11(tbl[11]),
    .in12(tbl[12]), .in13(tbl[13]), .in14(tbl[14]), .in15(tbl[15]),
    .out(out), .out_q(out_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [BITS-1:0] obs, input logic [BITS-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic load_words();
    for (int i = 0; i < 16; i++) tbl[i] = words[i];
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    words[0]  = 9'h004; words[1]  = 9'h024; words[2]  = 9'h0A1; words[3]  = 9'h003;
    words[4]  = 9'h110; words[5]  = 9'h08C; words[6]  = 9'h041; words[7]  = 9'h1E2;
    words[8]  = 9'h060; words[9]  = 9'h014; words[10] = 9'h0F0; words[11] = 9'h002;
    words[12] = 9'h001; words[13] = 9'h133; words[14] = 9'h018; words[15] = 9'h1C7;
    load_words();
    nrst = 1'b0;
    addr = 4'd0;

    // Reset state, and out keeps tracking while in reset, including across an edge.
    #2;
    check("rst_out_q", out_q, 9'h000);
    check("rst_out_tracks", out, 9'h004);
    @(posedge clk); #1;
    check("rst_wins_edge", out_q, 9'h000);
    addr = 4'd1; #1;
    check("rst_out_tracks2", out, 9'h024);
    @(negedge clk);
    nrst = 1'b1;

    // Table walk.
    for (int i = 0; i < 16; i++) begin
      addr = 4'(i); #1;
      check($sformatf("walk_%0d", i), out, words[i]);
    end

    // Isolation: unselected inputs must not disturb out; the selected one propagates at once.
    addr = 4'd5; #1;
    for (int j = 0; j < 16; j++) if (j != 5) tbl[j] = ~tbl[j];
    #1;
    check("iso_hold", out, 9'h08C);
    tbl[5] = 9'h0AA; #1;
    check("iso_follow", out, 9'h0AA);

    // Boundary words at indices 0 and 15.
    for (int j = 0; j < 16; j++) tbl[j] = 9'h000;
    tbl[0] = 9'h1FF; tbl[15] = 9'h155;
    addr = 4'd0; #1;
    check("bound_0", out, 9'h1FF);
    addr = 4'd15; #1;
    check("bound_15", out, 9'h155);

    // Register timing: one-cycle latency on out_q.
    load_words();
    @(posedge clk); #1;
    addr = 4'd3;
    @(posedge clk); #1;
    check("reg_in3", out_q, 9'h003);
    addr = 4'd7; #1;
    check("reg_out_now", out, 9'h1E2);
    check("reg_q_old", out_q, 9'h003);
    @(posedge clk); #1;
    check("reg_in7", out_q, 9'h1E2);

    // Asynchronous reset pulse between edges.
    #2 nrst = 1'b0;
    #1;
    check("arst_q", out_q, 9'h000);
    check("arst_out", out, 9'h1E2);
    #1 nrst = 1'b1;
    #1;
    check("arst_hold", out_q, 9'h000);
    @(posedge clk); #1;
    check("arst_recover", out_q, 9'h1E2);

    // Unknown address (only observable on a four-state simulator).
    addr = 4'b1x00; #1;
    if ($isunknown(addr)) check("x_addr", out, 9'bx_xxxx_xxxx);
    addr = 4'd12; #1;
    check("x_restore", out, 9'h001);
    @(posedge clk); #1;
    check("x_restore_q", out_q, 9'h001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
